// File: rtl/ucore_mem_pkg.sv
// Shared FSM encoding, response error code and default widths for the ucore memory
// responder and the generated cores that drive it.
package ucore_mem_pkg;

  localparam int unsigned UCORE_DATA_W      = 32;
  localparam int unsigned UCORE_ADDR_W      = 8;
  localparam int unsigned UCORE_MEM_DEPTH   = 64;
  localparam int unsigned UCORE_MEM_LATENCY = 2;

  localparam logic RSP_ERR_NONE = 1'b0;
  localparam logic RSP_ERR_OOR  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

  // Bit width able to index n items, never narrower than one bit.
  function automatic int unsigned min_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ucore_mem_array.sv
// Single-port DEPTH x DATA_W word array: synchronous write, registered read (1 cycle),
// no backpressure; read data holds until the next read enable.
module ucore_mem_array
  import ucore_mem_pkg::*;
#(
  parameter int unsigned DATA_W = UCORE_DATA_W,
  parameter int unsigned DEPTH  = UCORE_MEM_DEPTH,
  parameter int unsigned IDX_W  = min_width(UCORE_MEM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage itself is never reset; only the read register is.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ucore_mem_responder.sv
// Memory responder: one request at a time, response LATENCY cycles after accept; rsp_ready low holds RESP.
// UCORE_MEM_RSP_OVERLAP_EN lets a new request be accepted on the response handshake cycle.
module ucore_mem_responder
  import ucore_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = UCORE_DATA_W,
  parameter int unsigned ADDR_W  = UCORE_ADDR_W,
  parameter int unsigned DEPTH   = UCORE_MEM_DEPTH,
  parameter int unsigned LATENCY = UCORE_MEM_LATENCY
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned      IDX_W     = min_width(DEPTH);
  localparam int unsigned      CNT_W     = min_width(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  mem_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic              r_oor;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;

  logic              w_accept;
  logic              w_req_oor;
  logic [IDX_W-1:0]  w_req_idx;
  logic              w_go_resp;
  logic              w_cmt_write;
  logic              w_cmt_oor;
  logic [IDX_W-1:0]  w_cmt_idx;
  logic [DATA_W-1:0] w_cmt_wdata;
  logic              w_mem_we;
  logic              w_mem_re;
  logic [DATA_W-1:0] w_mem_rdata;

`ifdef UCORE_MEM_RSP_OVERLAP_EN
  assign req_ready = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);
`else
  assign req_ready = (r_state == ST_IDLE);
`endif

  assign w_accept  = req_valid && req_ready;
  assign w_req_oor = ({1'b0, req_addr} >= DEPTH_LIM);
  assign w_req_idx = req_addr[IDX_W-1:0];

  // With a single-cycle latency the accept edge is also the commit edge, so the
  // array must see the live request rather than the holding registers.
  assign w_go_resp   = ((r_state == ST_WAIT) && (r_cnt == CNT_W'(1))) ||
                       ((LATENCY == 1) && w_accept);
  assign w_cmt_write = (LATENCY == 1) ? req_write : r_write;
  assign w_cmt_oor   = (LATENCY == 1) ? w_req_oor : r_oor;
  assign w_cmt_idx   = (LATENCY == 1) ? w_req_idx : r_idx;
  assign w_cmt_wdata = (LATENCY == 1) ? req_wdata : r_wdata;

  assign w_mem_we = w_go_resp && w_cmt_write && !w_cmt_oor;
  assign w_mem_re = w_go_resp && !w_cmt_write && !w_cmt_oor;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_oor   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_oor   <= w_req_oor;
      r_idx   <= w_req_idx;
      r_wdata <= req_wdata;
      if (LATENCY == 1) begin
        r_state <= ST_RESP;
        r_cnt   <= '0;
      end else begin
        r_state <= ST_WAIT;
        r_cnt   <= CNT_LOAD;
      end
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_RESP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  ucore_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .i_clk   (clk),
    .i_rst   (areset),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_idx   (w_cmt_idx),
    .i_wdata (w_cmt_wdata),
    .o_rdata (w_mem_rdata)
  );

  // Response fields are decodes of held state, so they stay frozen while RESP waits.
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_err   = (rsp_valid && r_oor) ? RSP_ERR_OOR : RSP_ERR_NONE;
  assign rsp_rdata = (rsp_valid && !r_write && !r_oor) ? w_mem_rdata : '0;

endmodule
